// File: rtl/scan_chain_ctrl_pkg.sv
// rtl/scan_chain_ctrl_pkg.sv - shared types and helpers for the scan chain sequencer
// Purpose: sequencer state encoding and the bit-counter width calculation.
// Ports: none (package).
package scan_chain_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    PRESET    = 3'd1,
    SHIFT_IN  = 3'd2,
    CAPTURE   = 3'd3,
    SHIFT_OUT = 3'd4
  } state_e;

  // Counter must hold the largest reload value of any timed state.
  function automatic int cnt_width(input int chain_len, input int cap_cycles,
                                   input int preset_cycles);
    int m;
    m = chain_len;
    if (cap_cycles > m) m = cap_cycles;
    if (preset_cycles > m) m = preset_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// rtl/scan_chain_ctrl_if.sv - request/response interface between test access logic and the sequencer
// Purpose: groups the sequencer's request and result signals.
// Ports (signals):
//   start, preset_req, abort : one-cycle requests from the test access side
//   pattern [CHAIN_LEN]      : pattern sampled when start is accepted
//   busy, done               : sequencer status, done is a one-cycle pulse
//   response [CHAIN_LEN]     : captured chain contents, response[k] = flop k
// Modports: master = test access side, slave = sequencer.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern;
  logic                 preset_req;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response;

  modport master (
    output start, pattern, preset_req, abort,
    input  busy, done, response
  );

  modport slave (
    input  start, pattern, preset_req, abort,
    output busy, done, response
  );
endinterface

// File: rtl/scan_chain_ctrl_cnt.sv
// rtl/scan_chain_ctrl_cnt.sv - loadable down-counter with terminal flag
// Purpose: times each sequencer state; reloaded on every state entry.
// Ports:
//   CLK, RN  : clock and async active-low reset
//   load     : load load_val this edge (has priority over dec)
//   load_val : reload value
//   dec      : decrement this edge; holds at zero, never wraps
//   last     : count == 1, the state's final edge
module scan_chain_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan chain sequencer: shift-in, capture, shift-out, preset
// Purpose: drives one muxed-scan chain of CHAIN_LEN async-set flops.
// Ports:
//   CLK, RN    : clock shared with the chain, async active-low reset
//   ctl        : request/response interface (slave side)
//   chain_so   : scan-out from flop 0
//   chain_se   : scan enable to all flops
//   chain_si   : scan-in to flop CHAIN_LEN-1
//   chain_setn : active-low async set to all flops
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int   CHAIN_LEN     = 8,
  parameter int   CAP_CYCLES    = 1,
  parameter int   PRESET_CYCLES = 2,
  parameter logic FILL_BIT      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RN,
  scan_chain_ctrl_if.slave     ctl,
  input  logic                 chain_so,
  output logic                 chain_se,
  output logic                 chain_si,
  output logic                 chain_setn
);

  localparam logic [STATE_W-1:0] S_IDLE      = IDLE;
  localparam logic [STATE_W-1:0] S_PRESET    = PRESET;
  localparam logic [STATE_W-1:0] S_SHIFT_IN  = SHIFT_IN;
  localparam logic [STATE_W-1:0] S_CAPTURE   = CAPTURE;
  localparam logic [STATE_W-1:0] S_SHIFT_OUT = SHIFT_OUT;

  localparam int CNT_W = cnt_width(CHAIN_LEN, CAP_CYCLES, PRESET_CYCLES);
  localparam logic [CNT_W-1:0] LD_LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LD_CAP = CNT_W'(CAP_CYCLES);
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(PRESET_CYCLES);

  logic [STATE_W-1:0]   state;
  logic                 busy_q;
  logic                 done_q;
  logic [CHAIN_LEN-1:0] response_q;
  logic [CHAIN_LEN-1:0] pat_sr;
  // Only CHAIN_LEN-1 bits are stored; the final bit goes straight from
  // chain_so into response on the done edge.
  logic [CHAIN_LEN-1:1] rsp_sr;
  logic [CHAIN_LEN-1:0] rsp_nxt;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_last;

  assign rsp_nxt = {chain_so, rsp_sr};

  // Counter is reloaded on the edge that enters a timed state and
  // decremented on every other edge spent in one.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctl.preset_req) begin
          cnt_load = 1'b1;
          cnt_val  = LD_PRE;
        end else if (ctl.start) begin
          cnt_load = 1'b1;
          cnt_val  = LD_LEN;
        end
      end
      S_SHIFT_IN: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = LD_CAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = LD_LEN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: cnt_dec = 1'b1;
    endcase
  end

  scan_chain_ctrl_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RN       (RN),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= S_IDLE;
      chain_se   <= 1'b0;
      chain_si   <= 1'b0;
      chain_setn <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= '0;
      pat_sr     <= '0;
      rsp_sr     <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state != S_IDLE) && ctl.abort) begin
        state      <= S_IDLE;
        chain_se   <= 1'b0;
        chain_si   <= 1'b0;
        chain_setn <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // Preset wins; a start in the same cycle is dropped.
            if (ctl.preset_req) begin
              state      <= S_PRESET;
              chain_setn <= 1'b0;
              chain_se   <= 1'b0;
              busy_q     <= 1'b1;
            end else if (ctl.start) begin
              state    <= S_SHIFT_IN;
              pat_sr   <= ctl.pattern >> 1;
              chain_si <= ctl.pattern[0];
              chain_se <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          S_PRESET: begin
            if (cnt_last) begin
              state      <= S_IDLE;
              chain_setn <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
          S_SHIFT_IN: begin
            chain_si <= pat_sr[0];
            pat_sr   <= pat_sr >> 1;
            if (cnt_last) begin
              state    <= S_CAPTURE;
              chain_se <= 1'b0;
              chain_si <= FILL_BIT;
            end
          end
          S_CAPTURE: begin
            if (cnt_last) begin
              state    <= S_SHIFT_OUT;
              chain_se <= 1'b1;
              chain_si <= FILL_BIT;
            end
          end
          S_SHIFT_OUT: begin
            rsp_sr <= rsp_nxt[CHAIN_LEN-1:1];
            if (cnt_last) begin
              state      <= S_IDLE;
              response_q <= rsp_nxt;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              chain_se   <= 1'b0;
            end
          end
          default: begin
            state      <= S_IDLE;
            chain_se   <= 1'b0;
            chain_setn <= 1'b1;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.response = response_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - self-checking bench for scan_chain_ctrl with an 8-flop chain model
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic CLK;
  logic RN;
  logic chain_so, chain_se, chain_si, chain_setn;
  logic [N-1:0] q;

  int checks;
  int errors;
  int done_cnt;
  logic [N-1:0] exp_q[$];

  scan_chain_ctrl_if #(.CHAIN_LEN(N)) ctl ();

  scan_chain_ctrl #(
    .CHAIN_LEN     (N),
    .CAP_CYCLES    (1),
    .PRESET_CYCLES (2),
    .FILL_BIT      (1'b0)
  ) dut (
    .CLK        (CLK),
    .RN         (RN),
    .ctl        (ctl.slave),
    .chain_so   (chain_so),
    .chain_se   (chain_se),
    .chain_si   (chain_si),
    .chain_setn (chain_setn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Chain model: muxed-scan flops with async set; functional D = ~Q.
  initial q = '0;
  always @(posedge CLK or negedge chain_setn) begin
    if (!chain_setn) q <= '1;
    else if (chain_se) q <= {chain_si, q[N-1:1]};
    else q <= ~q;
  end
  assign chain_so = q[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest pending response.
  always @(negedge CLK) begin
    if (RN && ctl.done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("spurious_done", 32'(ctl.done), 32'd0);
      else check("response", 32'(ctl.response), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int nb;
    int low;
    int lat;
    int dc;
    checks = 0; errors = 0; done_cnt = 0;
    RN = 1'b0;
    ctl.start = 1'b0; ctl.pattern = '0; ctl.preset_req = 1'b0; ctl.abort = 1'b0;
    repeat (3) step();
    check("rst_se", 32'(chain_se), 32'd0);
    check("rst_si", 32'(chain_si), 32'd0);
    check("rst_setn", 32'(chain_setn), 32'd1);
    check("rst_busy", 32'(ctl.busy), 32'd0);
    check("rst_done", 32'(ctl.done), 32'd0);
    check("rst_resp", 32'(ctl.response), 32'd0);
    RN = 1'b1;
    step();

    // Pattern 0xA5 through a full sequence.
    ctl.start = 1'b1; ctl.pattern = 8'hA5; exp_q.push_back(8'h5A);
    step();
    ctl.start = 1'b0;
    check("si_first", 32'(chain_si), 32'd1);
    nb = 0;
    for (int i = 0; i < 17; i++) begin
      if (ctl.busy) nb++;
      check($sformatf("se_after_e%0d", i), 32'(chain_se), (i == 8) ? 32'd0 : 32'd1);
      if (i == 8) check("chain_loaded", 32'(q), 32'hA5);
      if (i == 9) check("chain_captured", 32'(q), 32'h5A);
      step();
    end
    check("busy_cycles", 32'(nb), 32'd17);
    check("done_e17", 32'(ctl.done), 32'd1);
    check("busy_e17", 32'(ctl.busy), 32'd0);
    check("se_e17", 32'(chain_se), 32'd0);
    step();
    check("done_one_cycle", 32'(ctl.done), 32'd0);
    check("resp_hold", 32'(ctl.response), 32'h5A);

    // Abort during shift-in.
    dc = done_cnt;
    ctl.start = 1'b1; ctl.pattern = 8'h12;
    step();
    ctl.start = 1'b0;
    repeat (5) step();
    ctl.abort = 1'b1;
    step();
    ctl.abort = 1'b0;
    check("abort_se", 32'(chain_se), 32'd0);
    check("abort_busy", 32'(ctl.busy), 32'd0);
    check("abort_setn", 32'(chain_setn), 32'd1);
    repeat (20) step();
    check("abort_no_done", 32'(done_cnt - dc), 32'd0);
    check("abort_resp", 32'(ctl.response), 32'h5A);

    // Preset and start together: preset wins.
    ctl.preset_req = 1'b1; ctl.start = 1'b1; ctl.pattern = 8'h77;
    step();
    ctl.preset_req = 1'b0; ctl.start = 1'b0;
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!chain_setn) low++;
      check($sformatf("preset_se_%0d", i), 32'(chain_se), 32'd0);
      step();
    end
    check("preset_low_cycles", 32'(low), 32'd2);
    check("preset_chain", 32'(q), 32'hFF);
    check("preset_busy", 32'(ctl.busy), 32'd0);
    check("preset_no_done", 32'(done_cnt - dc), 32'd0);

    // Pattern 0x00 after preset; a second start while busy is ignored.
    dc = done_cnt;
    ctl.start = 1'b1; ctl.pattern = 8'h00; exp_q.push_back(8'hFF);
    step();
    ctl.start = 1'b0;
    repeat (3) step();
    ctl.start = 1'b1; ctl.pattern = 8'h11;
    step();
    ctl.start = 1'b0;
    repeat (40) step();
    check("one_done", 32'(done_cnt - dc), 32'd1);
    check("idle_after", 32'(ctl.busy), 32'd0);

    // Async reset in the middle of shift-out.
    ctl.start = 1'b1; ctl.pattern = 8'h99;
    step();
    ctl.start = 1'b0;
    repeat (12) step();
    #2 RN = 1'b0;
    #1;
    check("arst_se", 32'(chain_se), 32'd0);
    check("arst_si", 32'(chain_si), 32'd0);
    check("arst_setn", 32'(chain_setn), 32'd1);
    check("arst_busy", 32'(ctl.busy), 32'd0);
    check("arst_done", 32'(ctl.done), 32'd0);
    check("arst_resp", 32'(ctl.response), 32'd0);
    #1 RN = 1'b1;
    step();

    // Normal latency after reset.
    ctl.start = 1'b1; ctl.pattern = 8'h3C; exp_q.push_back(8'hC3);
    step();
    ctl.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ctl.done) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'd17);
    repeat (2) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("total_done", 32'(done_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Sequencer for one scan chain built from the team's muxed-scan, async-set flip-flop cells (SE/SI/SETN/CLK/Q).
- Accepts a test pattern, shifts it in, pulses functional capture, shifts the response out, and reports it.
- Also drives the chain's shared async-set line for a timed preset.
- Sits between the test-access logic and the chain; one instance per chain.

Parameters:
CHAIN_LEN, 8, number of flops in the chain (>=2).
CAP_CYCLES, 1, functional capture cycles with SE=0 (>=1).
PRESET_CYCLES, 2, cycles chain_setn is held low for a preset (>=1).
FILL_BIT, 1'b0, value driven on SI during shift-out.

Ports:
CLK  input  1  rising-edge clock, shared with the chain.
RN  input  1  async active-low reset.
start  input  1  one-cycle request; accepted only in IDLE.
pattern  input  CHAIN_LEN  pattern; sampled on the accepting edge.
preset_req  input  1  one-cycle preset request; accepted only in IDLE.
abort  input  1  synchronous abort.
chain_so  input  1  chain scan-out (Q of flop index 0).
chain_se  output  1  scan enable to all chain flops.
chain_si  output  1  scan-in to flop index CHAIN_LEN-1.
chain_setn  output  1  active-low async set to all chain flops.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; response valid.
response  output  CHAIN_LEN  captured chain contents; response[k] = flop k.

Behaviour:
- Chain indexing: flop 0 drives chain_so; flop CHAIN_LEN-1 takes chain_si.
- All outputs are registered. Reset (RN low) takes effect asynchronously:
  - state=IDLE, chain_se=0, chain_si=0, chain_setn=1, busy=0, done=0, response=0.
  - Chain contents after reset are undefined.
- States: IDLE, PRESET, SHIFT_IN, CAPTURE, SHIFT_OUT.
- IDLE:
  - If preset_req: go to PRESET and set chain_setn=0. preset_req wins over a simultaneous start; that start is dropped.
  - Else if start: latch pattern into the shift register, go to SHIFT_IN, set chain_se=1 and chain_si=pattern[0].
  - start or preset_req while busy=1 is ignored.
- PRESET: chain_setn stays low for exactly PRESET_CYCLES cycles, then returns to 1 and the state returns to IDLE. chain_se=0 throughout.
- SHIFT_IN: CHAIN_LEN shift edges.
  - After each edge, chain_si presents the next pattern bit, pattern[0] first.
  - After the last edge, flop k holds pattern[k]; go to CAPTURE with chain_se=0.
- CAPTURE: CAP_CYCLES edges with chain_se=0, then go to SHIFT_OUT with chain_se=1 and chain_si=FILL_BIT.
- SHIFT_OUT: CHAIN_LEN edges.
  - Each edge shifts chain_so into the response shift register from the MSB side, so the first bit sampled ends in response[0].
  - On the final edge: response is updated, done=1 for one cycle, busy=0, chain_se=0, state=IDLE.
- Latency with start accepted at edge e0: shift-in edges e1..eN, capture edges eN+1..eN+CAP, shift-out edges eN+CAP+1..e2N+CAP.
  - done is high in the cycle after e2N+CAP.
  - For N=8, CAP=1: done follows e17.
- Bit counter is a down-counter of width $clog2(max(CHAIN_LEN,CAP_CYCLES,PRESET_CYCLES)+1). It reloads on every state entry and transitions at count 1; no wrap.
- abort in any non-IDLE state:
  - Next edge: state=IDLE, chain_se=0, chain_setn=1, busy=0.
  - No done pulse; response holds its previous value.
- abort in IDLE has no effect.
- response changes only on the done edge; it is stable at all other times.

Decomposition:
- Package scan_chain_ctrl_pkg: state enum (IDLE, PRESET, SHIFT_IN, CAPTURE, SHIFT_OUT) and a counter-width constant function.
- Sub-module scan_chain_ctrl_cnt: loadable down-counter with terminal flag.
- FSM, pattern shift register and response shift register stay in the top module.

Test Plan:
- Bench setup: CHAIN_LEN=8, CAP_CYCLES=1; the bench chain is 8 scan-flop models whose functional D is ~Q of the same flop.
- Pattern 0xA5, start at e0 -> chain_se high e0..e8, low for e9, high e10..e17; done after e17; response=0x5A; busy high 17 cycles.
- preset_req and start in the same IDLE cycle -> chain_setn low exactly 2 cycles; chain flops all 1; no shift activity; busy=0 after; no done.
- Preset, then start with pattern 0x00 -> response=0xFF. A second start while busy is ignored: exactly one done pulse.
- abort asserted at e5 of SHIFT_IN -> chain_se=0 and busy=0 after e6; no done; response unchanged from the previous 0x5A.
- RN pulsed low mid SHIFT_OUT -> all outputs at reset values immediately, without waiting for a clock edge. Then start with 0x3C -> response=0xC3 at normal latency.
